cdb_result_buffer: RTL and testbench
====================================

Name: cdb_result_buffer

Overview:
Small FIFO between one functional unit (pmfALU, mfALU or Memory) and the CDB arbitration (CDBHelper/CDB). It captures each {label, result} the unit produces and holds it until the CDB grants the broadcast. Through `available` it back-pressures the unit's state machine, so results are never lost when several units request the CDB in the same cycle. One instance sits per CDB source, driving that source's require bit and data/label lane.

Parameters:
DEPTH, 4, number of result entries; power of two, >= 2
DATA_W, 32, result data width
LABEL_W, 4, reservation-station label width; label 0 means "no producer"

Ports:
clk  input  1  clock; all state updates on rising edge
RST  input  1  reset, synchronous, active-high
WEN  input  1  unit presents a finished result this cycle
dataIn  input  DATA_W  result value
labelIn  input  LABEL_W  producing reservation-station label
available  output  1  buffer can accept a push this cycle (to unit state machine)
require  output  1  request for CDB broadcast (to CDBHelper/CDB sel)
requireAC  input  1  CDB grant for this source; same-cycle combinational response to require
dataOut  output  DATA_W  head entry data (CDB data lane)
labelOut  output  LABEL_W  head entry label (CDB label lane)
count  output  $clog2(DEPTH)+1  occupied entries
overflow  output  1  sticky: push attempted while full

Behaviour:
- Reset (RST=1 at clock edge):
  - count=0, rd/wr pointers=0, overflow=0.
  - require=0, dataOut=0, labelOut=0.
  - Reset wins over a simultaneous push or pop; in-flight entries are discarded.
- Storage: register array of DEPTH entries {label, data}.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- available = (count != DEPTH).
  - Purely registered-state based; it does not credit a same-cycle pop.
- push = WEN & available & (labelIn != 0).
  - WEN with labelIn==0 is ignored; it does not set overflow.
- WEN & !available & labelIn!=0 drops the result and sets overflow=1 until reset.
- require = (count != 0).
  - dataOut/labelOut show the head entry when require=1, and are forced to 0 otherwise.
- pop = require & requireAC.
  - Head is removed at the clock edge; rd pointer advances.
- requireAC while require=0 is ignored.
- Push and pop in the same cycle: count unchanged, both pointers advance.
  - Legal at any non-full occupancy.
  - When full, only the pop happens, because available=0.
- Latency: a result pushed in cycle N raises require in cycle N+1 (baseline).
- Ordering: strict FIFO; results broadcast in the order produced.
- While require=1 and no grant, head data/label hold stable.

Optional Feature:
CDB_RESULT_BYPASS_EN
- Defined:
  - When count==0 and a push is valid, require=1 and dataOut/labelOut=dataIn/labelIn in the same cycle.
  - If requireAC=1 in that cycle, the entry is consumed and not written; count stays 0.
  - Otherwise it is stored normally.
  - Zero-cycle latency.
- Undefined: baseline one-cycle latency; require is purely registered state.

Decomposition:
- Shared package holds:
  - DATA_W=32, LABEL_W=4.
  - NO_LABEL=4'b0.
  - CDB source index constants SRC_ALU=0, SRC_MUL=1, SRC_DIV=2, SRC_MEM=3, matching the require_s/requireAC_s bit order.
  - Result entry typedef {label, data}.
- No sub-module; pointer/count logic and the storage array are inline. All four CDB sources reuse this block as-is.

Test Plan:
1. Reset during occupancy: push {label 4'h3, 32'h11}, hold requireAC=0, assert RST -> next cycle count=0, require=0, dataOut=0, labelOut=0, overflow=0.
2. Single result: WEN with {4'h1, 32'hDEADBEEF}, requireAC=1 whenever require=1 -> require rises one cycle later with labelOut=4'h1, dataOut=32'hDEADBEEF; count returns to 0 after one grant cycle (bypass off).
3. Fill and back-pressure: 4 pushes with labels 1..4 and requireAC=0 -> count=4, available=0; a 5th WEN (label 5) sets overflow=1. Then grant 4 cycles -> labels 1,2,3,4 emerge in order.
4. Simultaneous push/pop at count=2 with requireAC=1 -> count stays 2, head advances, and the new entry appears after the remaining older one (tests wrap with 6+ total pushes).
5. Label-0 filter: WEN with labelIn=0, dataIn=32'h55 -> count unchanged, overflow unchanged, require stays 0.
6. With CDB_RESULT_BYPASS_EN, empty buffer: WEN {4'h7, 32'h1234} and requireAC=1 in the same cycle -> require=1, dataOut=32'h1234 that cycle, count remains 0 next cycle.

Source files
------------

// File: rtl/cdb_result_buffer_pkg.sv
// -----------------------------------------------------------------------------
// cdb_result_buffer_pkg
// Shared definitions for the per-source CDB result buffers.
//   DATA_W / LABEL_W : default result and reservation-station label widths
//   NO_LABEL         : label value meaning "no producer"
//   SRC_*            : CDB source index, matching the require_s/requireAC_s bit order
//   result_entry_t   : one buffered {label, data} result
// -----------------------------------------------------------------------------
package cdb_result_buffer_pkg;

  localparam int DATA_W  = 32;
  localparam int LABEL_W = 4;

  localparam logic [LABEL_W-1:0] NO_LABEL = 4'b0;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_DIV = 2;
  localparam int SRC_MEM = 3;

  typedef struct packed {
    logic [LABEL_W-1:0] label;
    logic [DATA_W-1:0]  data;
  } result_entry_t;

endpackage

// File: rtl/cdb_result_buffer.sv
// -----------------------------------------------------------------------------
// cdb_result_buffer
// Small FIFO between one functional unit and the CDB arbitration. Each valid
// {label, result} from the unit is held until the CDB grants the broadcast.
//
// Ports:
//   clk        rising-edge clock
//   RST        synchronous active-high reset
//   WEN        unit presents a finished result
//   dataIn     result value
//   labelIn    producing reservation-station label (0 = no producer, ignored)
//   available  buffer can accept a push this cycle (registered-state based)
//   require    CDB broadcast request
//   requireAC  CDB grant, combinational response to require
//   dataOut    head data lane (0 when not requesting)
//   labelOut   head label lane (0 when not requesting)
//   count      occupied entries
//   overflow   sticky: a valid push was attempted while full
//
// Build option:
//   CDB_RESULT_BYPASS_EN  when defined, a push into an empty buffer is
//                         presented on the CDB in the same cycle and, if
//                         granted, is consumed without being stored.
// -----------------------------------------------------------------------------
module cdb_result_buffer #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = cdb_result_buffer_pkg::DATA_W,
  parameter int LABEL_W = cdb_result_buffer_pkg::LABEL_W
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       WEN,
  input  logic [DATA_W-1:0]          dataIn,
  input  logic [LABEL_W-1:0]         labelIn,
  output logic                       available,
  output logic                       require,
  input  logic                       requireAC,
  output logic [DATA_W-1:0]          dataOut,
  output logic [LABEL_W-1:0]         labelOut,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  import cdb_result_buffer_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LABEL_W-1:0] label_mem_q [DEPTH];
  logic [DATA_W-1:0]  data_mem_q  [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             overflow_q, overflow_d;

  logic stored_valid;
  logic full;
  logic push_req;
  logic push;
  logic pop;
  logic bypass_valid;
  logic bypass_fire;
  logic write;

  assign stored_valid = (count_q != '0);
  assign full         = (count_q == CNT_W'(DEPTH));

  // Label 0 marks "no producer": such a strobe is neither stored nor an overflow.
  assign push_req = WEN && (labelIn != LABEL_W'(NO_LABEL));
  // available deliberately ignores a same-cycle pop, so a full buffer only pops.
  assign push     = push_req && !full;
  assign pop      = stored_valid && requireAC;

`ifdef CDB_RESULT_BYPASS_EN
  assign bypass_valid = push && !stored_valid;
  assign bypass_fire  = bypass_valid && requireAC;
`else
  assign bypass_valid = 1'b0;
  assign bypass_fire  = 1'b0;
`endif

  // A bypassed result that is granted immediately never enters storage.
  assign write = push && !bypass_fire;

  always_comb begin
    count_d    = count_q + CNT_W'(write) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(write);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    overflow_d = overflow_q | (push_req & full);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (RST) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only observable through
  // count/require, which are reset, so clearing the array would be dead logic.
  always_ff @(posedge clk) begin
    if (write) begin
      label_mem_q[wr_ptr_q] <= labelIn;
      data_mem_q[wr_ptr_q]  <= dataIn;
    end
  end

  assign available = !full;
  assign require   = stored_valid || bypass_valid;
  assign count     = count_q;
  assign overflow  = overflow_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dataOut  = '0;
    labelOut = '0;
    if (stored_valid) begin
      dataOut  = data_mem_q[rd_ptr_q];
      labelOut = label_mem_q[rd_ptr_q];
    end else if (bypass_valid) begin
      dataOut  = dataIn;
      labelOut = labelIn;
    end
  end

endmodule

// File: tb/tb_cdb_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_cdb_result_buffer
// Self-checking bench for cdb_result_buffer (DEPTH=4). A queue of pending
// results models the buffer; each cycle the expected outputs are derived from
// the queue and the current inputs, then the queue is advanced at the edge.
// -----------------------------------------------------------------------------
module tb_cdb_result_buffer;

  import cdb_result_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int VEC_W = 1 + 1 + LABEL_W + DATA_W + 3 + 1;

  logic               clk = 1'b0;
  logic               RST;
  logic               WEN;
  logic [DATA_W-1:0]  dataIn;
  logic [LABEL_W-1:0] labelIn;
  logic               available;
  logic               require;
  logic               requireAC;
  logic [DATA_W-1:0]  dataOut;
  logic [LABEL_W-1:0] labelOut;
  logic [2:0]         count;
  logic               overflow;

  cdb_result_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LABEL_W(LABEL_W)) dut (
    .clk       (clk),
    .RST       (RST),
    .WEN       (WEN),
    .dataIn    (dataIn),
    .labelIn   (labelIn),
    .available (available),
    .require   (require),
    .requireAC (requireAC),
    .dataOut   (dataOut),
    .labelOut  (labelOut),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  result_entry_t q[$];
  logic          m_overflow;
  logic [VEC_W-1:0] exp_vec;
  logic [VEC_W-1:0] obs_vec;

  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic [VEC_W-1:0] dut_vec();
    return {available, require, labelOut, dataOut, count, overflow};
  endfunction

  // Expected outputs for the current state and the inputs now being driven.
  task automatic model_outputs();
    logic               e_req;
    logic [LABEL_W-1:0] e_lab;
    logic [DATA_W-1:0]  e_dat;
    e_req = (q.size() != 0);
    e_lab = '0;
    e_dat = '0;
    if (q.size() != 0) begin
      e_lab = q[0].label;
      e_dat = q[0].data;
    end
`ifdef CDB_RESULT_BYPASS_EN
    if (q.size() == 0 && WEN && labelIn != 0) begin
      e_req = 1'b1;
      e_lab = labelIn;
      e_dat = dataIn;
    end
`endif
    exp_vec = {(q.size() != DEPTH), e_req, e_lab, e_dat, 3'(q.size()), m_overflow};
  endtask

  // Drive one cycle's inputs mid-cycle and compute the expected outputs.
  task automatic apply(input logic rst, input logic wen, input logic [LABEL_W-1:0] lab,
                       input logic [DATA_W-1:0] dat, input logic ac);
    @(negedge clk);
    RST = rst; WEN = wen; labelIn = lab; dataIn = dat; requireAC = ac;
    #1;
    model_outputs();
    obs_vec = dut_vec();
  endtask

  // Advance the model across the rising edge using the inputs of this cycle.
  task automatic commit();
    logic valid, push_ok, pop_ok, byp_fire;
    valid    = WEN && (labelIn != 0);
    push_ok  = valid && (q.size() != DEPTH);
    pop_ok   = (q.size() != 0) && requireAC;
    byp_fire = 1'b0;
`ifdef CDB_RESULT_BYPASS_EN
    byp_fire = push_ok && (q.size() == 0) && requireAC;
`endif
    @(posedge clk);
    if (RST) begin
      q.delete();
      m_overflow = 1'b0;
    end else begin
      if (valid && q.size() == DEPTH) m_overflow = 1'b1;
      if (pop_ok) void'(q.pop_front());
      if (push_ok && !byp_fire) q.push_back('{label: labelIn, data: dataIn});
    end
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, '0, '0, 1'b0);
    commit();
  endtask

  task automatic test_reset();
    apply(1'b0, 1'b1, 4'h3, 32'h11, 1'b0);
    commit();
    apply(1'b0, 1'b0, '0, '0, 1'b0);
    tests_run++;
    if (obs_vec !== exp_vec) begin
      tests_failed++;
      $display("FAIL reset_pre_occupied: got %h expected %h", obs_vec, exp_vec);
    end
    RST = 1'b1;
    commit();
    apply(1'b0, 1'b0, '0, '0, 1'b0);
    tests_run++;
    if (obs_vec !== exp_vec || obs_vec !== {1'b1, 1'b0, 4'h0, 32'h0, 3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_clears: got %h expected %h", obs_vec, exp_vec);
    end
    commit();
  endtask

  task automatic test_single();
    do_reset();
    apply(1'b0, 1'b1, 4'h1, 32'hDEADBEEF, 1'b1);
    tests_run++;
    if (obs_vec !== exp_vec) begin
      tests_failed++;
      $display("FAIL single_push_cycle: got %h expected %h", obs_vec, exp_vec);
    end
    commit();
    apply(1'b0, 1'b0, '0, '0, 1'b1);
`ifndef CDB_RESULT_BYPASS_EN
    tests_run++;
    if (obs_vec !== exp_vec || {require, labelOut, dataOut} !== {1'b1, 4'h1, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL single_require: got %h expected %h", obs_vec, exp_vec);
    end
`endif
    commit();
    apply(1'b0, 1'b0, '0, '0, 1'b0);
    tests_run++;
    if (obs_vec !== exp_vec || count !== 3'd0) begin
      tests_failed++;
      $display("FAIL single_drained: got %h expected %h", obs_vec, exp_vec);
    end
    commit();
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      apply(1'b0, 1'b1, 4'(i), 32'(i * 32'h100), 1'b0);
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++;
        $display("FAIL fill_push%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      commit();
    end
    for (int i = 1; i <= 5; i++) begin
      apply(1'b0, 1'b0, '0, '0, 1'b1);
      tests_run++;
      if (obs_vec !== exp_vec || (i <= 4 && labelOut !== 4'(i)) || overflow !== 1'b1) begin
        tests_failed++;
        $display("FAIL fill_drain%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      commit();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      apply(1'b0, 1'b1, 4'(i + 4), 32'hA000 + 32'(i), i > 2);
      tests_run++;
      if (obs_vec !== exp_vec || (i > 2 && (count !== 3'd2 || labelOut !== 4'(i + 2)))) begin
        tests_failed++;
        $display("FAIL b2b_cycle%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      commit();
    end
  endtask

  task automatic test_label0();
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b1, 4'h0, 32'h55, 1'b0);
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++;
        $display("FAIL label0_cycle%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      commit();
    end
  endtask

`ifdef CDB_RESULT_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    apply(1'b0, 1'b1, 4'h7, 32'h1234, 1'b1);
    tests_run++;
    if (obs_vec !== exp_vec || {require, dataOut} !== {1'b1, 32'h1234}) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle: got %h expected %h", obs_vec, exp_vec);
    end
    commit();
    apply(1'b0, 1'b0, '0, '0, 1'b0);
    tests_run++;
    if (obs_vec !== exp_vec || count !== 3'd0) begin
      tests_failed++;
      $display("FAIL bypass_consumed: got %h expected %h", obs_vec, exp_vec);
    end
    commit();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
            4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 2) == 0));
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      commit();
    end
  endtask

  initial begin
    RST = 1'b1; WEN = 1'b0; labelIn = '0; dataIn = '0; requireAC = 1'b0;
    m_overflow = 1'b0;
    do_reset();
    do_reset();
    test_reset();
    test_single();
    test_fill();
    test_label0();
    test_back_to_back();
`ifdef CDB_RESULT_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
